// File: rtl/router_inject_ni.sv
// Local-to-router injection network interface: two per-VC flit FIFOs, credit/lock-aware
// round-robin VC arbitration and a registered output stage. Define ROUTER_INJECT_STATS_EN for counters.
module router_inject_ni #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        RST_,
  input  logic [34:0] LDATA,
  input  logic        LVALID,
  input  logic        LVCH,
  output logic [1:0]  LRDY,
  output logic [34:0] ODATA,
  output logic        OVALID,
  output logic        OVCH,
  input  logic [1:0]  IRDY,
  input  logic [1:0]  IACK,
  input  logic [1:0]  ILCK
`ifdef ROUTER_INJECT_STATS_EN
  ,
  output logic [15:0] STAT_SENT0,
  output logic [15:0] STAT_SENT1,
  output logic [15:0] STAT_STALL
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [OW-1:0] OUTST_LIM = OW'(MAX_OUTST);

  logic [34:0]   mem_q [2][FIFO_DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] rptr_q [2];
  logic [CW-1:0] cnt_q  [2];
  logic [OW-1:0] outst_q[2];
  logic [1:0]    open_q;
  logic          rr_q;
  logic [34:0]   odata_q;
  logic          ovch_q;
  logic          ovalid_q;

  logic [1:0]    wr_en;
  logic [1:0]    elig;
  logic [1:0]    pop;
  logic          grant_any;
  logic          gvc;
  logic [34:0]   front [2];

  // Valid/ready: a local flit transfers only when LVALID && LRDY[LVCH]; anything else is dropped.
  always_comb begin
    LRDY  = 2'b00;
    wr_en = 2'b00;
    elig  = 2'b00;
    for (int v = 0; v < 2; v++) begin
      front[v] = mem_q[v][rptr_q[v]];
      LRDY[v]  = (cnt_q[v] != FULL_CNT);
      wr_en[v] = LVALID && (LVCH == v[0]) && (cnt_q[v] != FULL_CNT);
      // Locked router VC blocks only the start of a new packet, never one already open.
      elig[v]  = (cnt_q[v] != '0) && IRDY[v] && (outst_q[v] < OUTST_LIM) &&
                 !(ILCK[v] && !open_q[v] && front[v][33]);
    end
    grant_any = |elig;
    gvc       = (elig == 2'b11) ? rr_q : elig[1];
    pop       = grant_any ? (gvc ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (wr_en[v]) mem_q[v][wptr_q[v]] <= LDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_) begin
      for (int v = 0; v < 2; v++) begin
        wptr_q[v]  <= '0;
        rptr_q[v]  <= '0;
        cnt_q[v]   <= '0;
        outst_q[v] <= '0;
      end
      open_q   <= 2'b00;
      rr_q     <= 1'b0;
      odata_q  <= '0;
      ovch_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (wr_en[v]) wptr_q[v] <= wptr_q[v] + PW'(1);
        if (pop[v])   rptr_q[v] <= rptr_q[v] + PW'(1);
        cnt_q[v] <= cnt_q[v] + CW'(wr_en[v]) - CW'(pop[v]);
        // An ack with nothing outstanding is ignored so the counter cannot underflow.
        if (pop[v] && !(IACK[v] && outst_q[v] != '0))
          outst_q[v] <= outst_q[v] + OW'(1);
        else if (!pop[v] && IACK[v] && outst_q[v] != '0)
          outst_q[v] <= outst_q[v] - OW'(1);
        if (pop[v]) begin
          if (front[v][34:33] == 2'b01)      open_q[v] <= 1'b1;
          else if (front[v][34:33] == 2'b10) open_q[v] <= 1'b0;
        end
      end
      ovalid_q <= grant_any;
      if (grant_any) begin
        odata_q <= front[gvc];
        ovch_q  <= gvc;
        rr_q    <= ~gvc;
      end
    end
  end

  assign ODATA  = odata_q;
  assign OVCH   = ovch_q;
  assign OVALID = ovalid_q;

`ifdef ROUTER_INJECT_STATS_EN
  logic [15:0] sent0_q, sent1_q, stall_q;

  always_ff @(posedge clk) begin
    if (!RST_) begin
      sent0_q <= '0;
      sent1_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop[0] && sent0_q != 16'hFFFF) sent0_q <= sent0_q + 16'd1;
      if (pop[1] && sent1_q != 16'hFFFF) sent1_q <= sent1_q + 16'd1;
      if ((cnt_q[0] != '0 || cnt_q[1] != '0) && !grant_any && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign STAT_SENT0 = sent0_q;
  assign STAT_SENT1 = sent1_q;
  assign STAT_STALL = stall_q;
`endif

endmodule

// File: doc/router_inject_ni.md
ROUTER_INJECT_NI -- requirements
Module: router_inject_ni

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, flits per VC FIFO (power of 2, >=2).
REQ-002 Parameter MAX_OUTST, default 2, max un-acked flits per VC.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 RST_  input  1  reset, synchronous, active-low.
REQ-005 LDATA  input  35  local flit; [34:33] type (00 body, 01 head, 10 tail, 11 single), [32:0] payload.
REQ-006 LVALID  input  1  local flit valid.
REQ-007 LVCH  input  1  local flit target VC.
REQ-008 LRDY  output  2  per-VC FIFO not full; transfer when LVALID && LRDY[LVCH].
REQ-009 ODATA  output  35  flit toward router input port.
REQ-010 OVALID  output  1  ODATA valid this cycle.
REQ-011 OVCH  output  1  VC of ODATA.
REQ-012 IRDY  input  2  router VC buffer ready, per VC.
REQ-013 IACK  input  2  router per-VC one-cycle acknowledge of a received flit.
REQ-014 ILCK  input  2  router VC locked by a packet, per VC.

Function
REQ-015 Two independent FIFOs (VC0, VC1), FIFO_DEPTH each; write on local transfer to FIFO LVCH.
REQ-016 LRDY[v] SHALL be 0 when FIFO v is full, else 1; combinational from FIFO state only.
REQ-017 VC v eligible when: FIFO v non-empty && IRDY[v] && outst[v] < MAX_OUTST && !(ILCK[v] && !open[v] && front flit is head/single).
REQ-018 open[v] set when a head (01) is sent on v, cleared when a tail (10) is sent; single (11) leaves it 0.
REQ-019 Arbiter: round-robin between eligible VCs; pointer moves to the other VC after each grant; one grant per cycle max.
REQ-020 Granted flit is popped in cycle t and driven on ODATA/OVCH with OVALID=1 in cycle t+1 (registered, latency 1 from grant, min 2 cycles local-in to OVALID).
REQ-021 No grant in cycle t -> OVALID=0 in t+1; ODATA/OVCH hold last value.
REQ-022 outst[v] (width clog2(MAX_OUTST+1)): +1 on grant to v, -1 on IACK[v]; both same cycle -> unchanged; IACK[v] with outst[v]=0 ignored (no underflow).
REQ-023 FIFO write and pop of the same VC in one cycle SHALL both occur; full FIFO with simultaneous pop still reports LRDY[v]=0 that cycle (no bypass).
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter distinguishes full/empty.
REQ-025 Local write with LRDY[LVCH]=0 SHALL be dropped without state change.

Reset
REQ-026 RST_=0 at a clock edge: FIFOs empty, outst=0, open=0, RR pointer to VC0, OVALID=0, ODATA=0, OVCH=0; LRDY=2'b11 the cycle after.
REQ-027 Reset mid-packet discards all buffered and in-flight state; no flit issued in the cycle following reset deassertion's first edge unless granted in that cycle.

Configuration
REQ-028 Macro ROUTER_INJECT_STATS_EN defined: adds outputs STAT_SENT0, STAT_SENT1 (16-bit, flits sent per VC) and STAT_STALL (16-bit, cycles with a non-empty FIFO but no grant); all saturate at 16'hFFFF, cleared by reset.
REQ-029 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-030 Single flit 11 on VC0, IRDY=11 -> OVALID=1, OVCH=0, ODATA equal, 2 cycles after LVALID; outst[0]=1 until IACK[0].
REQ-031 Both FIFOs hold 3 flits, IRDY=11, IACK returned each cycle -> OVCH alternates 0,1,0,1,0,1.
REQ-032 VC0 write 5 flits with IRDY=00, FIFO_DEPTH=4 -> LRDY[0]=0 after 4th, 5th dropped; IRDY[0]=1 -> exactly 4 flits out.
REQ-033 MAX_OUTST=2, no IACK -> only 2 flits on VC1 then OVALID=0; one IACK[1] pulse -> exactly one more flit.
REQ-034 ILCK[0]=1, VC0 front is head -> no VC0 issue; packet in progress on VC0 (open=1) with ILCK[0]=1 -> body/tail continue.
REQ-035 RST_=0 while VC1 holds 2 flits and open[1]=1 -> next cycle OVALID=0, LRDY=11, no VC1 flit ever emitted.
